stack_mips_controller: RTL and testbench
========================================

# stack_mips_controller

Multi-cycle control FSM for the stack processor datapath (`stack_MIPS_DP`). It latches the 3-bit opcode during instruction fetch and sequences the PC, memory, IR, stack, A register, ALU-operand muxes and jump muxes through one instruction at a time. It takes only `zero` and `opcode` from the datapath and drives every datapath control input. A one-cycle `done` strobe marks each retired instruction.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- opcode  in  3  datapath `mem_out[7:5]`; valid only in FETCH
- zero  in  1  ALU zero flag, combinational from the datapath
- pcwrite, IorD, memwrite, memread, IRwrite, memTostack, push, tos, pop, Awrite, ALUsrcA, pcsrc, J, r_or_not  out  1 each  datapath controls
- ALUsrcB  out  2  00 = stack top (`d_out`), 01 = constant 4, 10 = constant 0
- aluop  out  2  00 add, 01 sub, 10 and, 11 not (of A)
- done  out  1  high in the final cycle of each instruction

## Operation
- Opcode map: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr.
- `addr` is the IR field, captured during FETCH.
- Internal `op_q[2:0]` is loaded from `opcode` on the FETCH edge. DECODE and later states dispatch on `op_q`, never on `opcode`.
- Outputs are Moore, decoded from the state. Any output not listed for a state is 0.
- States and asserted outputs:
  - FETCH: memread, IRwrite, IorD=0, ALUsrcA=0, ALUsrcB=01, aluop=00, pcsrc=1, J=0, pcwrite. Effect: PC <= PC+4. Next state: DECODE.
  - DECODE: no outputs. Next state by op_q: 000/001/010 -> POPA; 011 -> NOTOP; 100 -> MEMRD; 101 -> POPM; 110 -> JMP; 111 -> JZ.
  - POPA: tos, pop, Awrite. Effect: A <= top, then pop. Next: POPB.
  - POPB: tos, pop, ALUsrcA=1, r_or_not=0, ALUsrcB=00, aluop = op_q[1:0]. Effect: ALUout <= A op top, then pop. Next: PUSHR.
  - NOTOP: tos, pop, ALUsrcA=1, r_or_not=1, aluop=11. Effect: ALUout <= ~top, then pop. Next: PUSHR.
  - PUSHR: memTostack=1, push, done. Effect: pushes ALUout. Next: FETCH.
  - MEMRD: IorD=1, memread. Effect: MDR <= mem[addr]. Next: PUSHM.
  - PUSHM: memTostack=0, push, done. Effect: pushes MDR. Next: FETCH.
  - POPM: tos, pop, IorD=1, memwrite, done. Effect: mem[addr] <= top, then pop. Next: FETCH.
  - JMP: J=1, pcwrite, done. Effect: PC <= addr. Next: FETCH.
  - JZ: tos, ALUsrcA=1, r_or_not=1, ALUsrcB=10, aluop=00, done.
    - pcwrite = J = `zero`, evaluated in the same cycle.
    - The stack is not popped.
    - Next: FETCH.
- Operand order for SUB: the result is (first-popped) − (second-popped), i.e. A − top at POPB.
- The controller never asserts memread and memwrite together, and never asserts push and pop together.

## Timing
- Reset:
  - State <= FETCH and op_q <= 000.
  - While rst=1, every output, including `done`, is forced to 0. No PC, IR, memory or stack write occurs during a reset cycle.
  - The first FETCH is the cycle after rst falls.
- Reset asserted in any state aborts the instruction at the next edge. No partial push or pop is completed after that edge.
- Cycles per instruction, FETCH to `done` inclusive:
  - ADD/SUB/AND: 5
  - NOT: 4
  - PUSH: 4
  - POP: 3
  - JMP: 3
  - JZ: 3
- `done` is high for exactly one cycle per instruction. The next cycle is always FETCH.
- JZ depends on `zero`, which is combinational, so the branch decision and the PC write happen in the same cycle as the JZ state.
- Stack full/empty is not detected. Over- and underflow behaviour belongs to the stack; the controller sequence is unchanged.
- `opcode` changes outside FETCH have no effect.

## Test plan
- Reset: hold rst high 3 cycles with opcode=110. Require all outputs 0 and no pcwrite. After release, the first cycle shows FETCH outputs (memread=1, IRwrite=1, pcwrite=1, ALUsrcB=01).
- ADD sequence: opcode=000 at FETCH. Require the state trace FETCH, DECODE, POPA, POPB, PUSHR, with pop high in POPA and POPB only, aluop=00 in POPB, and push+memTostack=1+done in cycle 5. Repeat with SUB and AND, requiring aluop 01 and 10.
- PUSH then POP: opcode=100, then 101. Require memread with IorD=1 in cycle 3 and push with memTostack=0 in cycle 4. Then in the POP's 3rd cycle, require memwrite=1, IorD=1, pop=1.
- JZ with zero=1 and with zero=0: require pcwrite=J=1 in the JZ cycle for zero=1, pcwrite=0 for zero=0, and pop=0 in both cases.
- Opcode glitch: change opcode to 111 during DECODE of an ADD. Require the ADD sequence to proceed unchanged via the latched op_q.
- Mid-instruction reset: assert rst in POPB. Require all outputs 0 that cycle, no push afterward, and FETCH on the cycle after release.

Source files
------------

// File: rtl/stack_mips_controller.sv
// stack_mips_controller: multi-cycle Moore control FSM for the stack processor datapath
module stack_mips_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       pcwrite,
  output logic       IorD,
  output logic       memwrite,
  output logic       memread,
  output logic       IRwrite,
  output logic       memTostack,
  output logic       push,
  output logic       tos,
  output logic       pop,
  output logic       Awrite,
  output logic       ALUsrcA,
  output logic       pcsrc,
  output logic       J,
  output logic       r_or_not,
  output logic [1:0] ALUsrcB,
  output logic [1:0] aluop,
  output logic       done
);
  typedef enum logic [3:0] {
    FETCH, DECODE, POPA, POPB, NOTOP, PUSHR, MEMRD, PUSHM, POPM, JMP, JZ
  } state_t;
  state_t     state;
  logic [2:0] op_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      op_q  <= 3'b000;
    end else begin
      case (state)
        FETCH: begin
          op_q  <= opcode;
          state <= DECODE;
        end
        DECODE: state <= op_q == 3'b011 ? NOTOP :
                         op_q == 3'b100 ? MEMRD :
                         op_q == 3'b101 ? POPM  :
                         op_q == 3'b110 ? JMP   :
                         op_q == 3'b111 ? JZ    : POPA;
        POPA:    state <= POPB;
        POPB:    state <= PUSHR;
        NOTOP:   state <= PUSHR;
        MEMRD:   state <= PUSHM;
        default: state <= FETCH;
      endcase
    end
  end
  // Outputs are pure state decodes, gated off while rst is high so no write can leak during reset.
  logic run, s_fetch, s_popa, s_popb, s_not, s_pushr, s_memrd, s_pushm, s_popm, s_jmp, s_jz;
  always_comb begin
    run     = !rst;
    s_fetch = run && state == FETCH;
    s_popa  = run && state == POPA;
    s_popb  = run && state == POPB;
    s_not   = run && state == NOTOP;
    s_pushr = run && state == PUSHR;
    s_memrd = run && state == MEMRD;
    s_pushm = run && state == PUSHM;
    s_popm  = run && state == POPM;
    s_jmp   = run && state == JMP;
    s_jz    = run && state == JZ;
    pcwrite    = s_fetch || s_jmp || (s_jz && zero);
    J          = s_jmp || (s_jz && zero);
    IorD       = s_memrd || s_popm;
    memread    = s_fetch || s_memrd;
    memwrite   = s_popm;
    IRwrite    = s_fetch;
    pcsrc      = s_fetch;
    memTostack = s_pushr;
    push       = s_pushr || s_pushm;
    tos        = s_popa || s_popb || s_not || s_popm || s_jz;
    pop        = s_popa || s_popb || s_not || s_popm;
    Awrite     = s_popa;
    ALUsrcA    = s_popb || s_not || s_jz;
    r_or_not   = s_not || s_jz;
    ALUsrcB    = s_fetch ? 2'b01 : s_jz ? 2'b10 : 2'b00;
    aluop      = s_popb ? op_q[1:0] : s_not ? 2'b11 : 2'b00;
    done       = s_pushr || s_pushm || s_popm || s_jmp || s_jz;
  end
endmodule

// File: tb/tb_stack_mips_controller.sv
// tb_stack_mips_controller: directed per-cycle check of every control output against hand-built vectors
module tb_stack_mips_controller;
  logic clk = 0, rst = 1, zero = 0;
  logic [2:0] opcode = 3'b110;
  logic pcwrite, IorD, memwrite, memread, IRwrite, memTostack, push, tos, pop, Awrite, ALUsrcA, pcsrc, J, r_or_not, done;
  logic [1:0] ALUsrcB, aluop;
  int n_vec = 0, n_bad = 0;
  stack_mips_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pcwrite(pcwrite), .IorD(IorD), .memwrite(memwrite), .memread(memread), .IRwrite(IRwrite),
    .memTostack(memTostack), .push(push), .tos(tos), .pop(pop), .Awrite(Awrite), .ALUsrcA(ALUsrcA),
    .pcsrc(pcsrc), .J(J), .r_or_not(r_or_not), .ALUsrcB(ALUsrcB), .aluop(aluop), .done(done)
  );
  always #5 clk = ~clk;
  // {pcwrite,IorD,memwrite,memread,IRwrite,memTostack,push,tos,pop,Awrite,ALUsrcA,pcsrc,J,r_or_not,ALUsrcB,aluop,done}
  logic [18:0] ctl;
  assign ctl = {pcwrite, IorD, memwrite, memread, IRwrite, memTostack, push, tos, pop, Awrite,
                ALUsrcA, pcsrc, J, r_or_not, ALUsrcB, aluop, done};
  localparam logic [18:0] E_NONE  = 19'b0;
  localparam logic [18:0] E_FETCH = 19'b1_0_0_1_1_0_0_0_0_0_0_1_0_0_01_00_0;
  localparam logic [18:0] E_POPA  = 19'b0_0_0_0_0_0_0_1_1_1_0_0_0_0_00_00_0;
  localparam logic [18:0] E_POPB  = 19'b0_0_0_0_0_0_0_1_1_0_1_0_0_0_00_00_0;
  localparam logic [18:0] E_NOT   = 19'b0_0_0_0_0_0_0_1_1_0_1_0_0_1_00_11_0;
  localparam logic [18:0] E_PUSHR = 19'b0_0_0_0_0_1_1_0_0_0_0_0_0_0_00_00_1;
  localparam logic [18:0] E_MEMRD = 19'b0_1_0_1_0_0_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [18:0] E_PUSHM = 19'b0_0_0_0_0_0_1_0_0_0_0_0_0_0_00_00_1;
  localparam logic [18:0] E_POPM  = 19'b0_1_1_0_0_0_0_1_1_0_0_0_0_0_00_00_1;
  localparam logic [18:0] E_JMP   = 19'b1_0_0_0_0_0_0_0_0_0_0_0_1_0_00_00_1;
  localparam logic [18:0] E_JZ0   = 19'b0_0_0_0_0_0_0_1_0_0_1_0_0_1_10_00_1;
  localparam logic [18:0] E_JZ1   = 19'b1_0_0_0_0_0_0_1_0_0_1_0_1_1_10_00_1;
  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [18:0] exp);
    @(negedge clk);
    chk(tag, ctl, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic arith(input logic [2:0] op, input bit glitch);
    opcode = op;
    cyc("fetch", E_FETCH);
    if (glitch) opcode = 3'b111;
    cyc("decode", E_NONE);
    cyc("popa", E_POPA);
    cyc("popb", E_POPB | {16'b0, op[1:0], 1'b0});
    cyc("pushr", E_PUSHR);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) cyc("reset", E_NONE);
    rst = 0;
    arith(3'b000, 0);
    arith(3'b001, 0);
    arith(3'b010, 0);
    opcode = 3'b011;
    cyc("not_fetch", E_FETCH);
    cyc("not_decode", E_NONE);
    cyc("not_op", E_NOT);
    cyc("not_pushr", E_PUSHR);
    opcode = 3'b100;
    cyc("push_fetch", E_FETCH);
    opcode = 3'b000;
    cyc("push_decode", E_NONE);
    cyc("memrd", E_MEMRD);
    cyc("pushm", E_PUSHM);
    opcode = 3'b101;
    cyc("pop_fetch", E_FETCH);
    cyc("pop_decode", E_NONE);
    cyc("popm", E_POPM);
    opcode = 3'b110;
    cyc("jmp_fetch", E_FETCH);
    cyc("jmp_decode", E_NONE);
    cyc("jmp", E_JMP);
    opcode = 3'b111;
    zero = 1;
    cyc("jz1_fetch", E_FETCH);
    cyc("jz1_decode", E_NONE);
    cyc("jz_taken", E_JZ1);
    zero = 0;
    cyc("jz0_fetch", E_FETCH);
    cyc("jz0_decode", E_NONE);
    cyc("jz_not_taken", E_JZ0);
    arith(3'b000, 1);
    arith(3'b001, 1);
    opcode = 3'b001;
    cyc("rst_fetch", E_FETCH);
    cyc("rst_decode", E_NONE);
    cyc("rst_popa", E_POPA);
    rst = 1;
    cyc("rst_in_popb", E_NONE);
    rst = 0;
    opcode = 3'b110;
    cyc("after_rst_fetch", E_FETCH);
    cyc("after_rst_decode", E_NONE);
    cyc("after_rst_jmp", E_JMP);
    cyc("back_to_fetch", E_FETCH);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
